// File: rtl/router_fsm.sv
// Control FSM of the 1x4 packet router: sequences header/payload/parity loads and flow control.
// Optional feature: define ROUTER_FSM_SOFT_RESET_EN to let the FIFO timeout soft resets abort a packet.
module router_fsm (
    input  logic clk,
    input  logic resetn,
    input  logic pkt_valid,
    input  logic fifo_full,
    input  logic fifo_empty_0,
    input  logic fifo_empty_1,
    input  logic fifo_empty_2,
    input  logic fifo_empty_3,
    input  logic soft_reset_0,
    input  logic soft_reset_1,
    input  logic soft_reset_2,
    input  logic soft_reset_3,
    input  logic parity_done,
    input  logic low_packet_valid,
    output logic write_enb_reg,
    output logic detect_add,
    output logic ld_state,
    output logic laf_state,
    output logic lfd_state,
    output logic full_state,
    output logic rst_int_reg,
    output logic busy
);

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] LOAD_PARITY        = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] current_state;
    logic [2:0] next_state;
    logic       dest_empty;
    logic       soft_reset_any;

    assign dest_empty = fifo_empty_0 | fifo_empty_1 | fifo_empty_2 | fifo_empty_3;

`ifdef ROUTER_FSM_SOFT_RESET_EN
    assign soft_reset_any = soft_reset_0 | soft_reset_1 | soft_reset_2 | soft_reset_3;
`else
    // Soft resets are kept on the port list for drop-in compatibility but have no effect.
    logic unused_soft_reset;
    assign unused_soft_reset = soft_reset_0 ^ soft_reset_1 ^ soft_reset_2 ^ soft_reset_3;
    assign soft_reset_any    = 1'b0;
`endif

    // State register: hard reset beats soft reset beats the normal transition.
    always_ff @(posedge clk) begin
        if (resetn) begin
            current_state <= DECODE_ADDRESS;
        end else if (soft_reset_any) begin
            current_state <= DECODE_ADDRESS;
        end else begin
            current_state <= next_state;
        end
    end

    // Next-state logic; an idle decode state ignores every other input.
    always_comb begin
        next_state = current_state;
        case (current_state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    next_state = dest_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_packet_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (dest_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            default: next_state = DECODE_ADDRESS;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    assign detect_add    = (current_state == DECODE_ADDRESS);
    assign lfd_state     = (current_state == LOAD_FIRST_DATA);
    assign ld_state      = (current_state == LOAD_DATA);
    assign laf_state     = (current_state == LOAD_AFTER_FULL);
    assign full_state    = (current_state == FIFO_FULL_STATE);
    assign rst_int_reg   = (current_state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (current_state == LOAD_DATA) || (current_state == LOAD_PARITY) ||
                           (current_state == LOAD_AFTER_FULL);
    assign busy          = (current_state != DECODE_ADDRESS) && (current_state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Table-driven bench for router_fsm; the expected state after each edge is checked via the output decode.
module tb_router_fsm;

    localparam logic [2:0] S_DA  = 3'd0;
    localparam logic [2:0] S_LFD = 3'd1;
    localparam logic [2:0] S_LD  = 3'd2;
    localparam logic [2:0] S_LP  = 3'd3;
    localparam logic [2:0] S_FFS = 3'd4;
    localparam logic [2:0] S_LAF = 3'd5;
    localparam logic [2:0] S_WTE = 3'd6;
    localparam logic [2:0] S_CPE = 3'd7;

`ifdef ROUTER_FSM_SOFT_RESET_EN
    localparam bit SR_EN = 1'b1;
`else
    localparam bit SR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       pv;
        logic       ff;
        logic [3:0] emp;
        logic [3:0] srst;
        logic       pd;
        logic       lpv;
        logic [2:0] exp_state;
    } vec_t;

    logic clk = 1'b0;
    logic resetn, pkt_valid, fifo_full, parity_done, low_packet_valid;
    logic [3:0] emp, srst;
    logic write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg, busy;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]), .fifo_empty_3(emp[3]),
        .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]), .soft_reset_3(srst[3]),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    // Expected {write_enb_reg, detect_add, ld, laf, lfd, full, rst_int_reg, busy} for each state.
    function automatic logic [7:0] exp_outs(input logic [2:0] s);
        case (s)
            S_DA:    return 8'b0100_0000;
            S_LFD:   return 8'b0000_1001;
            S_LD:    return 8'b1010_0000;
            S_LP:    return 8'b1000_0001;
            S_FFS:   return 8'b0000_0101;
            S_LAF:   return 8'b1001_0001;
            S_WTE:   return 8'b0000_0001;
            default: return 8'b0000_0011;
        endcase
    endfunction

    task automatic add(input logic r, input logic p, input logic f, input logic [3:0] e,
                       input logic [3:0] s, input logic d, input logic l, input logic [2:0] x);
        vec_t v;
        v = '{rst: r, pv: p, ff: f, emp: e, srst: s, pd: d, lpv: l, exp_state: x};
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        resetn = v.rst; pkt_valid = v.pv; fifo_full = v.ff; emp = v.emp;
        srst = v.srst; parity_done = v.pd; low_packet_valid = v.lpv;
    endtask

    task automatic check(input string name, input logic [2:0] xs);
        logic [7:0] act;
        logic [7:0] req;
        act = {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg, busy};
        req = exp_outs(xs);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: outputs actual=%b required=%b (state %0d)", name, act, req, xs);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.exp_state);
    endtask

    initial begin
        vec_t v;
        resetn = 1'b1; pkt_valid = 1'b0; fifo_full = 1'b0; emp = 4'b0; srst = 4'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;

        // reset, then a normal packet
        add(1,0,0,4'b0000,4'b0000,0,0,S_DA);
        add(1,0,0,4'b0000,4'b0000,0,0,S_DA);
        add(0,0,0,4'b0000,4'b0000,0,0,S_DA);
        add(0,1,0,4'b1000,4'b0000,0,0,S_LFD);
        add(0,1,0,4'b1000,4'b0000,0,0,S_LD);
        add(0,1,0,4'b1000,4'b0000,0,0,S_LD);
        add(0,0,0,4'b1000,4'b0000,0,0,S_LP);
        add(0,0,0,4'b1000,4'b0000,0,0,S_CPE);
        add(0,0,0,4'b1000,4'b0000,0,0,S_DA);
        // full stall, fifo_full wins over pkt_valid low, parity_done exit
        add(0,1,0,4'b0001,4'b0000,0,0,S_LFD);
        add(0,1,0,4'b0001,4'b0000,0,0,S_LD);
        add(0,0,1,4'b0001,4'b0000,0,0,S_FFS);
        add(0,0,1,4'b0001,4'b0000,0,0,S_FFS);
        add(0,0,0,4'b0001,4'b0000,0,0,S_LAF);
        add(0,0,0,4'b0001,4'b0000,1,0,S_DA);
        // long packet: LAF back to LD, then low_packet_valid to LP
        add(0,1,0,4'b0010,4'b0000,0,0,S_LFD);
        add(0,1,0,4'b0010,4'b0000,0,0,S_LD);
        add(0,1,1,4'b0010,4'b0000,0,0,S_FFS);
        add(0,1,0,4'b0010,4'b0000,0,0,S_LAF);
        add(0,1,0,4'b0010,4'b0000,0,0,S_LD);
        add(0,1,1,4'b0010,4'b0000,0,0,S_FFS);
        add(0,0,0,4'b0010,4'b0000,0,0,S_LAF);
        add(0,0,0,4'b0010,4'b0000,0,1,S_LP);
        add(0,0,0,4'b0010,4'b0000,0,0,S_CPE);
        add(0,0,0,4'b0010,4'b0000,0,0,S_DA);
        // parity check sees a full FIFO
        add(0,1,0,4'b0100,4'b0000,0,0,S_LFD);
        add(0,1,0,4'b0100,4'b0000,0,0,S_LD);
        add(0,0,0,4'b0100,4'b0000,0,0,S_LP);
        add(0,0,1,4'b0100,4'b0000,0,0,S_CPE);
        add(0,0,1,4'b0100,4'b0000,0,0,S_FFS);
        add(0,0,0,4'b0100,4'b0000,0,0,S_LAF);
        add(0,0,0,4'b0100,4'b0000,1,0,S_DA);
        // wait for an empty destination
        add(0,1,0,4'b0000,4'b0000,0,0,S_WTE);
        add(0,1,0,4'b0000,4'b0000,0,0,S_WTE);
        add(0,1,0,4'b0000,4'b0000,0,0,S_WTE);
        add(0,1,0,4'b0000,4'b0000,0,0,S_WTE);
        add(0,1,0,4'b0001,4'b0000,0,0,S_LFD);
        add(0,1,0,4'b0001,4'b0000,0,0,S_LD);
        // soft reset in LOAD_DATA
        add(0,1,0,4'b0001,4'b0100,0,0,SR_EN ? S_DA : S_LD);
        add(0,1,0,4'b0001,4'b0000,0,0,SR_EN ? S_LFD : S_LD);
        add(0,1,0,4'b0001,4'b0000,0,0,S_LD);
        // hard reset mid-packet
        add(1,1,0,4'b0001,4'b0000,0,0,S_DA);
        add(0,0,0,4'b0001,4'b0000,0,0,S_DA);

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Hand sequence: soft reset held across edges keeps DECODE_ADDRESS despite pkt_valid.
        v = '{rst: 0, pv: 1, ff: 0, emp: 4'b0001, srst: 4'b0000, pd: 0, lpv: 0, exp_state: S_LFD};
        step(v, "seq_lfd");
        v.exp_state = S_LD;
        step(v, "seq_ld");
        v.srst = 4'b1000;
        v.exp_state = SR_EN ? S_DA : S_LD;
        for (int k = 0; k < 3; k++) step(v, $sformatf("seq_srst_hold%0d", k));
        v.srst = 4'b0000;
        v.exp_state = SR_EN ? S_LFD : S_LD;
        step(v, "seq_srst_release");

        // Hand sequence: reset wins over a full FIFO and soft reset while stalled.
        v = '{rst: 0, pv: 1, ff: 1, emp: 4'b0001, srst: 4'b0000, pd: 0, lpv: 0, exp_state: S_FFS};
        if (!SR_EN) step(v, "seq_ffs");
        v.rst = 1'b1; v.srst = 4'b0001; v.exp_state = S_DA;
        step(v, "seq_rst_prio");
        v.rst = 1'b0; v.pv = 1'b0; v.ff = 1'b0; v.srst = 4'b0000;
        step(v, "seq_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
